psram_ctrl: RTL and testbench

- SPI-mode (1-bit) controller for the on-board 8 MB QSPI PSRAM (ESP-PSRAM64-class) on the pcpu_main pins psram_ce/sclk/mosi/miso/sio2/sio3.
- Runs power-up init (reset-enable 0x66, reset 0x99).
- Turns single-word bus read/write requests from the CPU memory map into 0x03 slow-read / 0x02 write transactions.
- Presents the usual pComputer slave interface: a/d/we/rd/spo/ready.

---
 rtl/psram_pkg.sv | 27 ++
 rtl/psram_shift_engine.sv | 98 +++++++++
 rtl/psram_ctrl.sv | 155 +++++++++++++++
 tb/tb_psram_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Shared constants for the SPI-mode PSRAM controller: opcodes, FSM encoding,
// frame geometry and the byte-order helper used on both the write and read paths.
package psram_pkg;

  localparam logic [7:0] PSRAM_CMD_READ  = 8'h03;
  localparam logic [7:0] PSRAM_CMD_WRITE = 8'h02;
  localparam logic [7:0] PSRAM_CMD_RSTEN = 8'h66;
  localparam logic [7:0] PSRAM_CMD_RST   = 8'h99;

  localparam int PSRAM_FRAME_BITS = 64;
  localparam int PSRAM_CMD_BITS   = 8;

  typedef logic [2:0] psram_state_t;

  localparam psram_state_t ST_INIT_WAIT = 3'd0;
  localparam psram_state_t ST_RSTEN     = 3'd1;
  localparam psram_state_t ST_GAP       = 3'd2;
  localparam psram_state_t ST_RST       = 3'd3;
  localparam psram_state_t ST_IDLE      = 3'd4;
  localparam psram_state_t ST_XFER      = 3'd5;

  // The bus word is little-endian in PSRAM: byte 0 travels first on the wire.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/psram_shift_engine.sv
// MSB-first SPI mode-0 shifter for frames of up to 64 bits, with its own SCLK
// divider; CE is held low exactly while a frame is being shifted.
module psram_shift_engine #(
  parameter int CLK_HALF = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [6:0]  i_nbits,
  input  logic [63:0] i_tx,
  input  logic        i_miso,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rx,
  output logic        o_ce_n,
  output logic        o_sclk,
  output logic        o_mosi
);

  localparam int DIV_W = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HALF - 1);

  logic             r_busy;
  logic             r_ce_n;
  logic             r_sclk;
  logic             r_mosi;
  logic [DIV_W-1:0] r_div;
  logic [6:0]       r_bits;
  logic [63:0]      r_sh;
  logic [31:0]      r_rx;

  logic w_half_end;
  logic w_rise;
  logic w_fall;
  logic w_last;

  assign w_half_end = r_busy && (r_div == DIV_LAST);
  assign w_rise     = w_half_end && !r_sclk;
  assign w_fall     = w_half_end && r_sclk;
  assign w_last     = w_fall && (r_bits == 7'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_ce_n <= 1'b1;
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
      r_div  <= '0;
      r_bits <= 7'd0;
    end else if (!r_busy) begin
      if (i_start) begin
        r_busy <= 1'b1;
        r_ce_n <= 1'b0;
        r_sclk <= 1'b0;
        r_mosi <= i_tx[63];
        r_div  <= '0;
        r_bits <= i_nbits - 7'd1;
      end
    end else if (!w_half_end) begin
      r_div <= r_div + DIV_W'(1);
    end else begin
      r_div <= '0;
      if (!r_sclk) begin
        r_sclk <= 1'b1;
      end else begin
        // Falling edge: either present the next bit or close the frame.
        r_sclk <= 1'b0;
        if (r_bits == 7'd0) begin
          r_busy <= 1'b0;
          r_ce_n <= 1'b1;
          r_mosi <= 1'b0;
        end else begin
          r_mosi <= r_sh[63];
          r_bits <= r_bits - 7'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!r_busy && i_start) begin
      r_sh <= i_tx << 1;
    end else if (w_fall) begin
      r_sh <= r_sh << 1;
    end
    if (w_rise) begin
      r_rx <= {r_rx[30:0], i_miso};
    end
  end

  assign o_busy = r_busy;
  assign o_done = w_last;
  assign o_rx   = r_rx;
  assign o_ce_n = r_ce_n;
  assign o_sclk = r_sclk;
  assign o_mosi = r_mosi;

endmodule

// File: rtl/psram_ctrl.sv
// PSRAM controller: power-up reset sequence, then single-word 0x02/0x03
// transactions for the CPU bus, with a guaranteed CE-high gap between frames.
module psram_ctrl
  import psram_pkg::*;
#(
  parameter int CLK_HALF    = 1,
  parameter int INIT_CYCLES = 15000,
  parameter int CE_GAP      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] a,
  input  logic [31:0] d,
  input  logic        we,
  input  logic        rd,
  output logic [31:0] spo,
  output logic        ready,
  output logic        init_done,
  output logic        psram_ce,
  output logic        psram_sclk,
  output logic        psram_mosi,
  input  logic        psram_miso,
  output logic        psram_sio2,
  output logic        psram_sio3
);

  localparam int CNT_W = $clog2(INIT_CYCLES + CE_GAP + 1);

  psram_state_t r_state;
  psram_state_t w_next_state;

  logic [CNT_W-1:0] r_cnt;
  logic             r_rst_sent;
  logic             r_init_done;
  logic             r_op_wr;
  logic [31:0]      r_spo;
  logic             r_ready;

  logic        w_init_end;
  logic        w_gap_end;
  logic        w_accept;
  logic        w_start;
  logic [6:0]  w_nbits;
  logic [63:0] w_tx;
  logic        w_busy;
  logic        w_done;
  logic [31:0] w_rx;
  logic        w_unused;

  assign w_init_end = (r_cnt == CNT_W'(INIT_CYCLES - 1));
  assign w_gap_end  = (r_cnt == CNT_W'(CE_GAP - 1));
  assign w_accept   = r_init_done && !w_busy && (we || rd);
  assign w_unused   = &{1'b0, a[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT_WAIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT_WAIT: if (w_init_end) w_next_state = ST_RSTEN;
      ST_RSTEN:     if (w_done) w_next_state = ST_GAP;
      ST_GAP:       if (w_gap_end) w_next_state = r_rst_sent ? ST_IDLE : ST_RST;
      ST_RST:       if (w_done) w_next_state = ST_GAP;
      ST_IDLE:      if (w_accept) w_next_state = ST_XFER;
      ST_XFER:      if (w_done) w_next_state = ST_GAP;
      default:      w_next_state = ST_INIT_WAIT;
    endcase
  end

  // Frames are launched on the state-leaving cycle so CE falls on the next clk.
  always_comb begin
    w_start = 1'b0;
    w_nbits = 7'(PSRAM_CMD_BITS);
    w_tx    = 64'd0;
    case (r_state)
      ST_INIT_WAIT: begin
        w_start = w_init_end;
        w_tx    = {PSRAM_CMD_RSTEN, 56'd0};
      end
      ST_GAP: begin
        w_start = w_gap_end && !r_rst_sent;
        w_tx    = {PSRAM_CMD_RST, 56'd0};
      end
      ST_IDLE: begin
        w_start = w_accept;
        w_nbits = 7'(PSRAM_FRAME_BITS);
        w_tx    = {(we ? PSRAM_CMD_WRITE : PSRAM_CMD_READ), a[23:2], 2'b00,
                   (we ? byte_swap32(d) : 32'd0)};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_rst_sent  <= 1'b0;
      r_init_done <= 1'b0;
      r_ready     <= 1'b0;
      r_spo       <= 32'd0;
    end else begin
      if ((r_state == ST_INIT_WAIT && !w_init_end) || (r_state == ST_GAP && !w_gap_end)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      if (r_state == ST_RST && w_done) begin
        r_rst_sent <= 1'b1;
      end
      if (r_state == ST_GAP && w_gap_end && r_rst_sent) begin
        r_init_done <= 1'b1;
      end
      r_ready <= (r_state == ST_XFER) && w_done;
      if (r_state == ST_XFER && w_done && !r_op_wr) begin
        r_spo <= byte_swap32(w_rx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && w_accept) begin
      r_op_wr <= we;
    end
  end

  psram_shift_engine #(
    .CLK_HALF(CLK_HALF)
  ) u_engine (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_nbits (w_nbits),
    .i_tx    (w_tx),
    .i_miso  (psram_miso),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_rx    (w_rx),
    .o_ce_n  (psram_ce),
    .o_sclk  (psram_sclk),
    .o_mosi  (psram_mosi)
  );

  assign spo        = r_spo;
  assign ready      = r_ready;
  assign init_done  = r_init_done;
  assign psram_sio2 = 1'b1;
  assign psram_sio3 = 1'b1;

endmodule

// File: tb/tb_psram_ctrl.sv
// Scoreboard bench for psram_ctrl: a behavioural PSRAM checks every CE frame,
// a ready monitor checks spo and completion latency against queued expectations.
module tb_psram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [23:0] a = '0;
  logic [31:0] d = '0;
  logic        we = 1'b0, rd = 1'b0;
  logic [31:0] spo;
  logic        ready, init_done, psram_ce, psram_sclk, psram_mosi, psram_sio2, psram_sio3;
  logic        psram_miso = 1'b0;

  logic        rst2 = 1'b1;
  logic [23:0] a2 = '0;
  logic [31:0] d2 = '0;
  logic        we2 = 1'b0, rd2 = 1'b0;
  logic [31:0] spo2;
  logic        ready2, init_done2, ce2, sclk2, mosi2, sio2_2, sio3_2;
  logic        miso2 = 1'b0;

  psram_ctrl dut (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .rd(rd), .spo(spo), .ready(ready),
    .init_done(init_done), .psram_ce(psram_ce), .psram_sclk(psram_sclk),
    .psram_mosi(psram_mosi), .psram_miso(psram_miso), .psram_sio2(psram_sio2),
    .psram_sio3(psram_sio3)
  );

  psram_ctrl #(.CLK_HALF(2), .INIT_CYCLES(30), .CE_GAP(4)) dut2 (
    .clk(clk), .rst(rst2), .a(a2), .d(d2), .we(we2), .rd(rd2), .spo(spo2), .ready(ready2),
    .init_done(init_done2), .psram_ce(ce2), .psram_sclk(sclk2), .psram_mosi(mosi2),
    .psram_miso(miso2), .psram_sio2(sio2_2), .psram_sio3(sio3_2)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct { logic [31:0] spo; int t; int lat; } rsp_t;
  typedef struct { logic [63:0] f; int len; } frm_t;
  rsp_t rq[$];
  rsp_t rq2[$];
  frm_t fq[$];
  rsp_t re, re2;
  frm_t me;

  // Ready monitors: every pulse must match a queued expectation.
  always @(negedge clk) begin
    if (ready) begin
      if (rq.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        re = rq.pop_front();
        check("spo", 64'(spo), 64'(re.spo));
        check("ready_latency", 64'(cyc - re.t), 64'(re.lat));
        check("ce_high_at_ready", 64'(psram_ce), 64'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (ready2) begin
      if (rq2.size() == 0) begin
        check("unexpected_ready2", 64'd1, 64'd0);
      end else begin
        re2 = rq2.pop_front();
        check("spo2", 64'(spo2), 64'(re2.spo));
        check("ready_latency2", 64'(cyc - re2.t), 64'(re2.lat));
      end
    end
  end

  // Behavioural PSRAM: captures MOSI on SCLK rise, answers 0x03 from mem.
  logic [7:0]  mem [0:1023];
  int          mcnt = 0;
  logic [63:0] mframe = '0;
  logic [7:0]  mcmd = '0;
  logic [23:0] maddr = '0;
  logic [31:0] mword = '0;

  always @(posedge psram_sclk or posedge psram_ce) begin
    if (psram_ce) begin
      if (mcnt > 0) begin
        if (fq.size() == 0) begin
          check("unexpected_frame", 64'(mcnt), 64'd0);
        end else begin
          me = fq.pop_front();
          if (me.len == 0) begin
            check("aborted_frame_short", 64'(mcnt < 64), 64'd1);
          end else begin
            check("frame_len", 64'(mcnt), 64'(me.len));
            check("frame_bits", mframe, me.f);
          end
        end
        if (mcnt == 64 && mcmd == 8'h02) begin
          for (int i = 0; i < 4; i++) mem[10'(maddr + 24'(i))] = mframe[31-8*i -: 8];
        end
      end
      mcnt = 0;
      mframe = '0;
      psram_miso = 1'b0;
    end else begin
      mframe = {mframe[62:0], psram_mosi};
      mcnt++;
      if (mcnt == 8) mcmd = mframe[7:0];
      if (mcnt == 32) begin
        maddr = mframe[23:0];
        mword = {mem[maddr[9:0]], mem[10'(maddr + 24'd1)], mem[10'(maddr + 24'd2)],
                 mem[10'(maddr + 24'd3)]};
      end
      if (mcnt >= 32 && mcnt < 64 && mcmd == 8'h03) psram_miso = mword[63-mcnt];
    end
  end

  int          m2cnt = 0;
  logic [31:0] pat2 = 32'hC3A50F96;
  always @(posedge sclk2 or posedge ce2) begin
    if (ce2) begin
      m2cnt = 0;
      miso2 = 1'b0;
    end else begin
      m2cnt++;
      if (m2cnt >= 32 && m2cnt < 64) miso2 = pat2[63-m2cnt];
    end
  end

  task automatic wait_ce(input logic lvl, input int budget, input string name, output int t);
    int k;
    k = 0;
    while (psram_ce !== lvl && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (psram_ce !== lvl) check(name, 64'(psram_ce), 64'(lvl));
    t = cyc;
  endtask

  task automatic wait_init(input int budget);
    int k;
    k = 0;
    while (!init_done && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic issue(input logic w, input logic r, input logic [23:0] addr,
                       input logic [31:0] data, output int t);
    @(negedge clk);
    a = addr; d = data; we = w; rd = r;
    @(negedge clk);
    t = cyc;
    we = 1'b0; rd = 1'b0;
    check("ce_low_after_accept", 64'(psram_ce), 64'd0);
  endtask

  logic done2 = 1'b0;

  initial begin
    int k;
    int t2;
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    k = 0;
    while (!init_done2 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("init_done2", 64'(init_done2), 64'd1);
    @(negedge clk);
    a2 = 24'h000104; rd2 = 1'b1;
    @(negedge clk);
    t2 = cyc;
    rd2 = 1'b0;
    rq2.push_back('{32'h960FA5C3, t2, 256});
    repeat (300) @(negedge clk);
    done2 = 1'b1;
  end

  initial begin
    int t0, t1, t2, t3, t4, t;
    int k;
    repeat (3) @(negedge clk);
    check("rst_ce", 64'(psram_ce), 64'd1);
    check("rst_sclk", 64'(psram_sclk), 64'd0);
    check("rst_mosi", 64'(psram_mosi), 64'd0);
    check("rst_spo", 64'(spo), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("sio2_sio3", 64'({psram_sio2, psram_sio3}), 64'd3);

    fq.push_back('{64'h66, 8});
    fq.push_back('{64'h99, 8});
    rst = 1'b0;
    t0 = cyc;
    repeat (10) @(negedge clk);
    we = 1'b1; rd = 1'b1;
    @(negedge clk);
    we = 1'b0; rd = 1'b0;
    wait_ce(1'b0, 16000, "init_ce_fall_timeout", t1);
    check("init_wait_len", 64'(t1 - t0), 64'd15000);
    wait_ce(1'b1, 100, "rsten_end_timeout", t2);
    check("rsten_len", 64'(t2 - t1), 64'd16);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    wait_ce(1'b0, 20, "rst_cmd_timeout", t3);
    check("init_gap_len", 64'(t3 - t2), 64'd4);
    wait_ce(1'b1, 100, "rst_end_timeout", t4);
    check("init_done_low_in_gap", 64'(init_done), 64'd0);
    wait_init(20);
    check("init_done_delay", 64'(cyc - t4), 64'd4);

    fq.push_back('{64'h02000104_EFBEADDE, 64});
    issue(1'b1, 1'b0, 24'h000104, 32'hDEADBEEF, t);
    rq.push_back('{32'h0, t, 128});
    repeat (140) @(negedge clk);

    fq.push_back('{64'h03000104_00000000, 64});
    issue(1'b0, 1'b1, 24'h000107, 32'h0, t);
    rq.push_back('{32'hDEADBEEF, t, 128});
    repeat (140) @(negedge clk);

    fq.push_back('{64'h02000200_78563412, 64});
    issue(1'b1, 1'b0, 24'h000200, 32'h12345678, t);
    rq.push_back('{32'hDEADBEEF, t, 128});
    repeat (140) @(negedge clk);

    // Read with a second request arriving mid-frame.
    fq.push_back('{64'h03000200_00000000, 64});
    issue(1'b0, 1'b1, 24'h000200, 32'h0, t);
    rq.push_back('{32'h12345678, t, 128});
    repeat (19) @(negedge clk);
    a = 24'h000300; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    repeat (130) @(negedge clk);

    fq.push_back('{64'h02000300_A5A50000, 64});
    issue(1'b1, 1'b1, 24'h000300, 32'h0000A5A5, t);
    rq.push_back('{32'h12345678, t, 128});
    repeat (140) @(negedge clk);

    // Reset 40 cycles into a read: frame aborts, no ready, init repeats.
    fq.push_back('{64'h0, 0});
    issue(1'b0, 1'b1, 24'h000104, 32'h0, t);
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ce", 64'(psram_ce), 64'd1);
    check("midrst_sclk", 64'(psram_sclk), 64'd0);
    check("midrst_init_done", 64'(init_done), 64'd0);
    check("midrst_spo", 64'(spo), 64'd0);
    fq.push_back('{64'h66, 8});
    fq.push_back('{64'h99, 8});
    rst = 1'b0;
    wait_init(16000);
    check("reinit_done", 64'(init_done), 64'd1);

    fq.push_back('{64'h03000104_00000000, 64});
    issue(1'b0, 1'b1, 24'h000104, 32'h0, t);
    rq.push_back('{32'hDEADBEEF, t, 128});
    repeat (140) @(negedge clk);

    k = 0;
    while (!done2 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("inst2_done", 64'(done2), 64'd1);
    check("rsp_queue_drained", 64'(rq.size()), 64'd0);
    check("rsp2_queue_drained", 64'(rq2.size()), 64'd0);
    check("frame_queue_drained", 64'(fq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
